pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the synchronous 5-stage core. Generates the 2-bit select codes for the `mux2_2`-style selectors in front of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves four hazard sources:
- data-memory wait;
- multi-cycle MDU ops, using an internal FSM and counter;
- taken-branch redirect;
- load-use.

Select encoding, shared by all `*_sel` outputs: 2'b00 ADVANCE (load new data), 2'b01 HOLD (recirculate current value), 2'b10 BUBBLE (load reset value). 2'b11 is never driven.

---
 rtl/hazard_pkg.sv | 43 ++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   sel_e         : 2-bit select code driven to each pipeline register mux
//   hz_state_e    : controller FSM states (RUN, MDU_WAIT)
//   sel_pattern_t : one select code per stage, ordered pc/ifid/idex/exmem/memwb
//   PAT_*         : the fixed select patterns the controller can emit
// Optional feature macro used by the top level: HAZARD_PERF_CNT_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        SEL_ADVANCE = 2'b00,
        SEL_HOLD    = 2'b01,
        SEL_BUBBLE  = 2'b10
    } sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        sel_e pc;
        sel_e ifid;
        sel_e idex;
        sel_e exmem;
        sel_e memwb;
    } sel_pattern_t;

    localparam sel_pattern_t PAT_NORMAL   = '{SEL_ADVANCE, SEL_ADVANCE, SEL_ADVANCE, SEL_ADVANCE, SEL_ADVANCE};
    localparam sel_pattern_t PAT_MEMWAIT  = '{SEL_HOLD,    SEL_HOLD,    SEL_HOLD,    SEL_HOLD,    SEL_BUBBLE};
    localparam sel_pattern_t PAT_MDUSTALL = '{SEL_HOLD,    SEL_HOLD,    SEL_HOLD,    SEL_BUBBLE,  SEL_ADVANCE};
    localparam sel_pattern_t PAT_REDIRECT = '{SEL_ADVANCE, SEL_BUBBLE,  SEL_BUBBLE,  SEL_ADVANCE, SEL_ADVANCE};
    localparam sel_pattern_t PAT_LOADUSE  = '{SEL_HOLD,    SEL_HOLD,    SEL_BUBBLE,  SEL_ADVANCE, SEL_ADVANCE};
    // Every stage loads its reset value while the core is held in reset.
    localparam sel_pattern_t PAT_RESET    = '{SEL_BUBBLE,  SEL_BUBBLE,  SEL_BUBBLE,  SEL_BUBBLE,  SEL_BUBBLE};

    // True when any stage recirculates its value, i.e. the pipeline is stalled.
    function automatic logic pattern_has_hold(input sel_pattern_t p);
        return (p.pc == SEL_HOLD) || (p.ifid == SEL_HOLD) || (p.idex == SEL_HOLD) ||
               (p.exmem == SEL_HOLD) || (p.memwb == SEL_HOLD);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect
// Purely combinational load-use comparator.
//   id_rs1_i, id_rs2_i           : source registers of the instruction in ID
//   id_rs1_used_i, id_rs2_used_i : source actually read
//   ex_rd_i                      : destination of the instruction in EX
//   ex_mem_read_i                : EX instruction is a load
//   load_use_o                   : ID needs a value the EX load has not produced yet
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    output logic                  load_use_o
);

    // Register 0 is hardwired to zero, so a load into it never creates a dependency.
    always_comb begin
        load_use_o = ex_mem_read_i && (ex_rd_i != '0) &&
                     ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                      (id_rs2_used_i && (id_rs2_i == ex_rd_i)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard controller for the 5-stage core: drives the select codes in front of
// the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//   clk, reset_n            : clock, synchronous active-low reset
//   id_rs1/2, id_rs1/2_used : ID-stage source registers and their use flags
//   ex_rd, ex_mem_read      : EX-stage destination and load flag
//   ex_mdu_op               : EX holds a multi-cycle MDU op
//   ex_branch_taken         : EX resolved a taken branch/jump
//   mem_wait                : data memory not ready
//   *_sel                   : per-stage select codes (Mealy, same-cycle)
//   mdu_start, mdu_busy     : MDU accept pulse and busy flag
// Optional: define HAZARD_PERF_CNT_EN to add perf_stall_cycles/perf_flush_cycles.
// MDU_LATENCY must be at least 2.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MDU_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_mdu_op,
    input  logic                  ex_branch_taken,
    input  logic                  mem_wait,
    output logic [1:0]            pc_sel,
    output logic [1:0]            ifid_sel,
    output logic [1:0]            idex_sel,
    output logic [1:0]            exmem_sel,
    output logic [1:0]            memwb_sel,
    output logic                  mdu_start,
    output logic                  mdu_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_cycles
`endif
);

    localparam int CNT_W = $clog2(MDU_LATENCY);

    hz_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sel_pattern_t pat;
    logic         load_use;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rs1_used_i (id_rs1_used),
        .id_rs2_used_i (id_rs2_used),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_mem_read),
        .load_use_o    (load_use)
    );

    // Select pattern and next state. In RUN the hazard sources are prioritised
    // mem_wait > MDU > redirect > load-use. Accepting an MDU op preloads cnt with
    // MDU_LATENCY-2 so that the accept cycle plus cnt+1 waiting cycles give the
    // full EX occupancy. In MDU_WAIT the counter keeps draining during mem_wait,
    // and release to RUN only happens once cnt is zero and memory is ready.
    always_comb begin
        pat       = PAT_NORMAL;
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdu_start = 1'b0;
        if (!reset_n) begin
            pat = PAT_RESET;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        pat = PAT_MEMWAIT;
                    end else if (ex_mdu_op) begin
                        pat       = PAT_MDUSTALL;
                        cnt_d     = CNT_W'(MDU_LATENCY - 2);
                        state_d   = MDU_WAIT;
                        mdu_start = 1'b1;
                    end else if (ex_branch_taken) begin
                        pat = PAT_REDIRECT;
                    end else if (load_use) begin
                        pat = PAT_LOADUSE;
                    end
                end
                MDU_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        pat   = mem_wait ? PAT_MEMWAIT : PAT_MDUSTALL;
                    end else if (mem_wait) begin
                        pat = PAT_MEMWAIT;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // FSM and MDU counter registers; reset also aborts an MDU op in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive the per-stage selects from the chosen pattern.
    always_comb begin
        pc_sel    = pat.pc;
        ifid_sel  = pat.ifid;
        idex_sel  = pat.idex;
        exmem_sel = pat.exmem;
        memwb_sel = pat.memwb;
        mdu_busy  = reset_n && (state_q == MDU_WAIT);
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Stall cycles are those where any stage holds; flush cycles are redirects.
    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (pattern_has_hold(pat)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (pat == PAT_REDIRECT) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl: a table of single-cycle RUN-state
// vectors, hand-written multi-cycle MDU/reset sequences, and randomized
// stimulus compared against a cycle-level reference model.
// Honours HAZARD_PERF_CNT_EN to also check the performance counters.
module tb_pipe_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;

    // Expected patterns, pc/ifid/idex/exmem/memwb, written out bit-for-bit.
    localparam logic [9:0] E_NORM  = 10'b00_00_00_00_00;
    localparam logic [9:0] E_MEMW  = 10'b01_01_01_01_10;
    localparam logic [9:0] E_MDUS  = 10'b01_01_01_10_00;
    localparam logic [9:0] E_REDIR = 10'b00_10_10_00_00;
    localparam logic [9:0] E_LDUS  = 10'b01_01_10_00_00;
    localparam logic [9:0] E_BUB   = 10'b10_10_10_10_10;

    typedef struct {
        logic          rstN;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          rs1Used;
        logic          rs2Used;
        logic [AW-1:0] exRd;
        logic          memRead;
        logic          mduOp;
        logic          branch;
        logic          memWait;
    } vec_t;

    typedef struct {
        vec_t        in;
        logic [11:0] exp;
    } tableRec_t;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_rs1_used, id_rs2_used;
    logic          ex_mem_read, ex_mdu_op, ex_branch_taken, mem_wait;
    logic [1:0]    pc_sel, ifid_sel, idex_sel, exmem_sel, memwb_sel;
    logic          mdu_start, mdu_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   perf_stall_cycles, perf_flush_cycles;
`endif

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: whether an MDU op occupies EX, and how many
    // cycles ago it was accepted.
    bit mBusy = 1'b0;
    int mAge  = 0;
    int mStall = 0;
    int mFlush = 0;

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (AW),
        .MDU_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_mdu_op       (ex_mdu_op),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .pc_sel          (pc_sel),
        .ifid_sel        (ifid_sel),
        .idex_sel        (idex_sel),
        .exmem_sel       (exmem_sel),
        .memwb_sel       (memwb_sel),
        .mdu_start       (mdu_start),
        .mdu_busy        (mdu_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cycles (perf_flush_cycles)
`endif
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input logic rstN, input logic [AW-1:0] rs1, input logic rs1Used,
                                   input logic [AW-1:0] rs2, input logic rs2Used, input logic [AW-1:0] exRd,
                                   input logic memRead, input logic mduOp, input logic branch,
                                   input logic memWait);
        vec_t v;
        v.rstN = rstN; v.rs1 = rs1; v.rs1Used = rs1Used; v.rs2 = rs2; v.rs2Used = rs2Used;
        v.exRd = exRd; v.memRead = memRead; v.mduOp = mduOp; v.branch = branch; v.memWait = memWait;
        return v;
    endfunction

    // Expected {sels, mdu_start, mdu_busy} from the current model state and inputs.
    function automatic logic [11:0] modelExpect(input vec_t v);
        bit lu;
        lu = v.memRead && (v.exRd != 0) &&
             ((v.rs1Used && (v.rs1 == v.exRd)) || (v.rs2Used && (v.rs2 == v.exRd)));
        if (!v.rstN)               return {E_BUB, 1'b0, 1'b0};
        if (mBusy) begin
            if (v.memWait)         return {E_MEMW, 1'b0, 1'b1};
            if (mAge < LAT - 1)    return {E_MDUS, 1'b0, 1'b1};
            return {E_NORM, 1'b0, 1'b1};
        end
        if (v.memWait)             return {E_MEMW, 1'b0, 1'b0};
        if (v.mduOp)               return {E_MDUS, 1'b1, 1'b0};
        if (v.branch)              return {E_REDIR, 1'b0, 1'b0};
        if (lu)                    return {E_LDUS, 1'b0, 1'b0};
        return {E_NORM, 1'b0, 1'b0};
    endfunction

    // Advance the model across one clock edge.
    task automatic modelAdvance(input vec_t v, input logic [9:0] sel);
        if (!v.rstN) begin
            mBusy = 1'b0; mAge = 0; mStall = 0; mFlush = 0;
        end else begin
            if (sel[9:8] == 2'b01 || sel[7:6] == 2'b01 || sel[5:4] == 2'b01 ||
                sel[3:2] == 2'b01 || sel[1:0] == 2'b01) mStall++;
            if (sel == E_REDIR) mFlush++;
            if (mBusy) begin
                if (!v.memWait && mAge >= LAT - 1) mBusy = 1'b0;
                else mAge++;
            end else if (!v.memWait && v.mduOp) begin
                mBusy = 1'b1;
                mAge  = 1;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset_n         = v.rstN;
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_rs1_used     = v.rs1Used;
        id_rs2_used     = v.rs2Used;
        ex_rd           = v.exRd;
        ex_mem_read     = v.memRead;
        ex_mdu_op       = v.mduOp;
        ex_branch_taken = v.branch;
        mem_wait        = v.memWait;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] exp);
        logic [11:0] act;
        act = {pc_sel, ifid_sel, idex_sel, exmem_sel, memwb_sel, mdu_start, mdu_busy};
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got sel=%b start=%b busy=%b, expected sel=%b start=%b busy=%b",
                      name, act[11:2], act[1], act[0], exp[11:2], exp[1], exp[0]);
    endtask

    // One full cycle: drive inputs just after the edge, check mid-cycle, clock the model.
    task automatic checkCycle(input vec_t v, input logic [11:0] exp, input string name);
        logic [11:0] mexp;
        applyStimulus(v);
        mexp = modelExpect(v);
        #4;
        checkOutput(name, exp);
        @(posedge clk);
        modelAdvance(v, mexp[11:2]);
        #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic checkPerf(input string name, input int expStall, input int expFlush);
        checkCount++;
        if (perf_stall_cycles === 32'(expStall)) passCount++;
        else $display("[TB] FAIL %s stall: got %0d, expected %0d", name, perf_stall_cycles, expStall);
        checkCount++;
        if (perf_flush_cycles === 32'(expFlush)) passCount++;
        else $display("[TB] FAIL %s flush: got %0d, expected %0d", name, perf_flush_cycles, expFlush);
    endtask
`endif

    initial begin
        vec_t idle, rst, v;
        tableRec_t tbl[11];

        idle = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst  = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // RUN-state single-cycle vectors.
        tbl[0]  = '{idle,                                    {E_NORM,  2'b00}};
        tbl[1]  = '{mkVec(1, 0, 0, 5, 1, 5, 1, 0, 0, 0),   {E_LDUS,  2'b00}};
        tbl[2]  = '{mkVec(1, 0, 0, 0, 1, 0, 1, 0, 0, 0),   {E_NORM,  2'b00}};
        tbl[3]  = '{mkVec(1, 7, 0, 3, 1, 7, 1, 0, 0, 0),   {E_NORM,  2'b00}};
        tbl[4]  = '{mkVec(1, 7, 1, 3, 1, 7, 1, 0, 0, 0),   {E_LDUS,  2'b00}};
        tbl[5]  = '{mkVec(1, 7, 1, 7, 1, 7, 0, 0, 0, 0),   {E_NORM,  2'b00}};
        tbl[6]  = '{mkVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0),   {E_REDIR, 2'b00}};
        tbl[7]  = '{mkVec(1, 0, 0, 5, 1, 5, 1, 0, 1, 0),   {E_REDIR, 2'b00}};
        tbl[8]  = '{mkVec(1, 0, 0, 5, 1, 5, 1, 0, 1, 1),   {E_MEMW,  2'b00}};
        tbl[9]  = '{mkVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 1),   {E_MEMW,  2'b00}};
        tbl[10] = '{mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 1),   {E_MEMW,  2'b00}};

        // Reset held three cycles with an MDU request in the middle one.
        v = rst;
        checkCycle(v, {E_BUB, 2'b00}, "reset0");
        v.mduOp = 1'b1;
        checkCycle(v, {E_BUB, 2'b00}, "reset1");
        v.mduOp = 1'b0;
        checkCycle(v, {E_BUB, 2'b00}, "reset2");
        checkCycle(idle, {E_NORM, 2'b00}, "postReset");

        for (int i = 0; i < 11; i++)
            checkCycle(tbl[i].in, tbl[i].exp, $sformatf("table[%0d]", i));

        // MDU op held: accept, two more stalls, then release.
        v = idle; v.mduOp = 1'b1;
        checkCycle(v, {E_MDUS, 2'b10}, "mdu c0");
        checkCycle(v, {E_MDUS, 2'b01}, "mdu c1");
        checkCycle(v, {E_MDUS, 2'b01}, "mdu c2");
        checkCycle(v, {E_NORM, 2'b01}, "mdu c3");
        checkCycle(idle, {E_NORM, 2'b00}, "mdu after");

        // mem_wait for two cycles at the cnt==0 cycle keeps the op in EX.
        checkCycle(v, {E_MDUS, 2'b10}, "mduWait c0");
        checkCycle(v, {E_MDUS, 2'b01}, "mduWait c1");
        checkCycle(v, {E_MDUS, 2'b01}, "mduWait c2");
        v.memWait = 1'b1;
        checkCycle(v, {E_MEMW, 2'b01}, "mduWait c3");
        checkCycle(v, {E_MEMW, 2'b01}, "mduWait c4");
        v.memWait = 1'b0;
        checkCycle(v, {E_NORM, 2'b01}, "mduWait c5");
        checkCycle(idle, {E_NORM, 2'b00}, "mduWait after");

        // mem_wait during the stall phase does not extend the op.
        checkCycle(v, {E_MDUS, 2'b10}, "mduEarly c0");
        v.memWait = 1'b1;
        checkCycle(v, {E_MEMW, 2'b01}, "mduEarly c1");
        v.memWait = 1'b0;
        checkCycle(v, {E_MDUS, 2'b01}, "mduEarly c2");
        checkCycle(v, {E_NORM, 2'b01}, "mduEarly c3");
        checkCycle(idle, {E_NORM, 2'b00}, "mduEarly after");

        // Reset in the middle of an MDU op returns to RUN.
        checkCycle(v, {E_MDUS, 2'b10}, "mduRst c0");
        checkCycle(v, {E_MDUS, 2'b01}, "mduRst c1");
        checkCycle(rst, {E_BUB, 2'b00}, "mduRst reset");
        checkCycle(idle, {E_NORM, 2'b00}, "mduRst after");

`ifdef HAZARD_PERF_CNT_EN
        // Three load-use stalls and two redirects from a fresh reset.
        checkCycle(rst, {E_BUB, 2'b00}, "perf reset");
        checkCycle(tbl[1].in, {E_LDUS, 2'b00}, "perf lu0");
        checkCycle(idle, {E_NORM, 2'b00}, "perf idle0");
        checkCycle(tbl[1].in, {E_LDUS, 2'b00}, "perf lu1");
        checkCycle(tbl[6].in, {E_REDIR, 2'b00}, "perf br0");
        checkCycle(tbl[4].in, {E_LDUS, 2'b00}, "perf lu2");
        checkCycle(tbl[6].in, {E_REDIR, 2'b00}, "perf br1");
        checkCycle(idle, {E_NORM, 2'b00}, "perf idle1");
        checkPerf("perf directed", 3, 2);
`endif

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            v.rstN    = ($urandom_range(0, 29) != 0);
            v.rs1     = AW'($urandom_range(0, 3));
            v.rs2     = AW'($urandom_range(0, 3));
            v.rs1Used = 1'($urandom_range(0, 1));
            v.rs2Used = 1'($urandom_range(0, 1));
            v.exRd    = AW'($urandom_range(0, 3));
            v.memRead = 1'($urandom_range(0, 1));
            v.mduOp   = ($urandom_range(0, 5) == 0);
            v.branch  = ($urandom_range(0, 4) == 0);
            v.memWait = ($urandom_range(0, 4) == 0);
            checkCycle(v, modelExpect(v), $sformatf("random[%0d]", i));
        end

`ifdef HAZARD_PERF_CNT_EN
        checkPerf("perf random", mStall, mFlush);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
